mm_seq_multiplier: RTL and testbench



---
 rtl/mm_mul_pkg.sv | 18 +
 rtl/mm_seq_multiplier_shift_add_core.sv | 54 +++++
 rtl/mm_seq_multiplier.sv | 151 +++++++++++++++
 tb/tb_mm_seq_multiplier.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mm_mul_pkg.sv
// Shared types and constants for the memory-mapped sequential multiplier.
package mm_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MCAND  = 2'd0;
  localparam logic [1:0] ADDR_MPLIER = 2'd1;
  localparam logic [1:0] ADDR_PROD   = 2'd2;
  localparam logic [1:0] ADDR_STAT   = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/mm_seq_multiplier_shift_add_core.sv
// Shift-add engine: one multiplier bit per step, accumulating into a 2*WIDTH-bit sum.
module shift_add_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_sh_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  // Next accumulator value; equals acc_r whenever no step is taken.
  always_comb begin
    acc_next = acc_r;
    if (step && mplier_r[0]) begin
      acc_next = acc_r + mcand_sh_r;
    end else begin
      acc_next = acc_r;
    end
    last = (cnt_r == LAST_BIT);
  end

  // Operand shift registers, accumulator and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r      <= {(2*WIDTH){1'b0}};
      mcand_sh_r <= {(2*WIDTH){1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (load) begin
      acc_r      <= {(2*WIDTH){1'b0}};
      mcand_sh_r <= {{WIDTH{1'b0}}, mcand};
      mplier_r   <= mplier;
      cnt_r      <= {CW{1'b0}};
    end else if (step) begin
      acc_r      <= acc_next;
      mcand_sh_r <= mcand_sh_r << 1;
      mplier_r   <= mplier_r >> 1;
      cnt_r      <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/mm_seq_multiplier.sv
// Bus-mapped sequential multiplier: operand/product/status registers and control FSM.
// Define SIGNED_MUL_EN for two's-complement operands (adds one FIX cycle of latency).
module mm_seq_multiplier
  import mm_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 e,
  input  logic                 w,
  input  logic                 r,
  input  logic [1:0]           addr,
  input  logic [WIDTH-1:0]     DIn,
  output logic [2*WIDTH-1:0]   DOut,
  output logic                 busy,
  output logic                 done
);

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] dout_r;
  logic               busy_r;
  logic               done_r;
  logic               write_s;
  logic               read_s;
  logic               start_s;
  logic [2*WIDTH-1:0] stat_s;
  logic [WIDTH-1:0]   core_mcand_s;
  logic [WIDTH-1:0]   core_mplier_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               last_s;
  logic               step_s;

`ifdef SIGNED_MUL_EN
  logic neg_r;

  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign core_mcand_s  = magnitude(mcand_r);
  assign core_mplier_s = magnitude(mplier_r);
`else
  assign core_mcand_s  = mcand_r;
  assign core_mplier_s = mplier_r;
`endif

  assign write_s = e & w;
  assign read_s  = e & r;
  assign start_s = write_s && (addr == ADDR_STAT) && DIn[0] && (state_r == IDLE);
  assign step_s  = (state_r == RUN);
  assign DOut    = dout_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Status word as seen on the bus.
  always_comb begin
    stat_s            = {(2*WIDTH){1'b0}};
    stat_s[STAT_BUSY] = busy_r;
    stat_s[STAT_DONE] = done_r;
  end

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (start_s),
    .step     (step_s),
    .mcand    (core_mcand_s),
    .mplier   (core_mplier_s),
    .acc_next (acc_next_s),
    .last     (last_s)
  );

  // Bus register file, read port and control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      dout_r   <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SIGNED_MUL_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      if (write_s && !busy_r) begin
        case (addr)
          ADDR_MCAND:  mcand_r  <= DIn;
          ADDR_MPLIER: mplier_r <= DIn;
          default:     ;
        endcase
      end

      // Reads see pre-edge register values, so a same-edge write is not visible yet.
      if (read_s) begin
        case (addr)
          ADDR_MCAND:  dout_r <= {{WIDTH{1'b0}}, mcand_r};
          ADDR_MPLIER: dout_r <= {{WIDTH{1'b0}}, mplier_r};
          ADDR_PROD:   dout_r <= prod_r;
          ADDR_STAT:   dout_r <= stat_s;
          default:     dout_r <= dout_r;
        endcase
      end

      case (state_r)
        IDLE: begin
          if (start_s) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
`ifdef SIGNED_MUL_EN
            neg_r   <= mcand_r[WIDTH-1] ^ mplier_r[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (last_s) begin
`ifdef SIGNED_MUL_EN
            state_r <= FIX;
`else
            prod_r  <= acc_next_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
`endif
          end
        end
        FIX: begin
`ifdef SIGNED_MUL_EN
          prod_r  <= neg_r ? (~acc_next_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_next_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
`endif
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq_multiplier.sv
// Scoreboard bench for mm_seq_multiplier: reads push expected data, a negedge monitor checks DOut.
module tb_mm_seq_multiplier;
  import mm_mul_pkg::*;

  localparam int WIDTH = 16;
`ifdef SIGNED_MUL_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              e = 1'b0;
  logic              w = 1'b0;
  logic              r = 1'b0;
  logic [1:0]        addr = 2'd0;
  logic [WIDTH-1:0]  DIn = '0;
  logic [2*WIDTH-1:0] DOut;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  logic rd_v = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  mm_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .e(e), .w(w), .r(r), .addr(addr),
    .DIn(DIn), .DOut(DOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_v <= e & r;

  // Monitor: one registered read result per accepted read strobe.
  always @(negedge clk) begin
    logic [31:0] ev;
    string nm;
    if (rd_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%08h want=none", DOut);
      end else begin
        ev = exp_q.pop_front();
        nm = name_q.pop_front();
        if (DOut !== ev) begin
          errors++;
          $display("FAIL %s got=%08h want=%08h", nm, DOut, ev);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", nm, act, expv);
    end
  endtask

  task automatic bus(input logic wr, input logic rd, input logic [1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    e = 1'b1; w = wr; r = rd; addr = a; DIn = d;
    @(posedge clk);
    #1;
    e = 1'b0; w = 1'b0; r = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] expv, input string nm);
    exp_q.push_back(expv);
    name_q.push_back(nm);
    bus(1'b0, 1'b1, a, '0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [31:0] expv, input string nm);
    wr(ADDR_MCAND, a);
    wr(ADDR_MPLIER, b);
    wr(ADDR_STAT, 16'h0001);
    wait_done(nm);
    rd(ADDR_PROD, expv, nm);
  endtask

  initial begin
    #1;
    chk("reset_dout", DOut, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(ADDR_PROD, 32'd0, "reset_prod");
    rd(ADDR_STAT, 32'd0, "reset_stat");

    // 3 x 5 with cycle-exact busy window
    wr(ADDR_MCAND, 16'd3);
    wr(ADDR_MPLIER, 16'd5);
    wr(ADDR_STAT, 16'h0001);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("busy_window", {30'd0, done, busy}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("complete_flags", {30'd0, done, busy}, 32'd2);
    rd(ADDR_PROD, 32'h0000000F, "prod_3x5");
    rd(ADDR_MCAND, 32'd3, "rd_mcand");
    rd(ADDR_MPLIER, 32'd5, "rd_mplier");

    // Status write with DIn[0]=0 does not start
    wr(ADDR_STAT, 16'h0000);
    @(negedge clk);
    chk("no_start_busy", {31'd0, busy}, 32'd0);

`ifdef SIGNED_MUL_EN
    mul(16'hFFFF, 16'hFFFF, 32'h00000001, "prod_ffff");
`else
    mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "prod_ffff");
`endif
    rd(ADDR_STAT, 32'd2, "stat_done");

    // Writes and restart during RUN are ignored; product reads stay at the prior result
    wr(ADDR_MCAND, 16'd3);
    wr(ADDR_MPLIER, 16'd5);
    wr(ADDR_STAT, 16'h0001);
    wr(ADDR_MCAND, 16'd7);
    wr(ADDR_STAT, 16'h0001);
`ifdef SIGNED_MUL_EN
    rd(ADDR_PROD, 32'h00000001, "prod_during_run");
`else
    rd(ADDR_PROD, 32'hFFFE0001, "prod_during_run");
`endif
    rd(ADDR_MCAND, 32'd3, "mcand_held");
    repeat (LAT - 5) @(posedge clk);
    rd(ADDR_STAT, 32'd1, "stat_completion_edge");
    rd(ADDR_STAT, 32'd2, "stat_after_completion");
    rd(ADDR_PROD, 32'h0000000F, "prod_orig_operands");

    // Address 2 writes are ignored
    wr(ADDR_PROD, 16'h1234);
    rd(ADDR_PROD, 32'h0000000F, "prod_write_ignored");

    // Same-edge read+write returns the pre-write value
    bus(1'b1, 1'b0, ADDR_MCAND, 16'd6);
    exp_q.push_back(32'd6);
    name_q.push_back("rw_same_edge");
    bus(1'b1, 1'b1, ADDR_MCAND, 16'd9);
    rd(ADDR_MCAND, 32'd9, "rw_post_write");

`ifdef SIGNED_MUL_EN
    mul(16'hFFFD, 16'd5, 32'hFFFFFFF1, "prod_neg3x5");
`else
    mul(16'hFFFD, 16'd5, 32'h0004FFF1, "prod_fffdx5");
`endif
    mul(16'h8000, 16'h8000, 32'h40000000, "prod_8000sq");

    // Reset in the middle of RUN
    wr(ADDR_MCAND, 16'd3);
    wr(ADDR_MPLIER, 16'd5);
    wr(ADDR_STAT, 16'h0001);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_dout", DOut, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(ADDR_PROD, 32'd0, "midrst_prod");
    rd(ADDR_MCAND, 32'd0, "midrst_mcand");
    mul(16'd6, 16'd7, 32'd42, "prod_after_rst");

    // Back-to-back start on the edge right after completion
    wr(ADDR_MPLIER, 16'd10);
    wr(ADDR_STAT, 16'h0001);
    wait_done("b2b_first");
    wr(ADDR_STAT, 16'h0001);
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second");
    rd(ADDR_PROD, 32'd60, "prod_b2b");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
